// File: rtl/ps2_kbd_rx_if.sv
// Register-window side of the PS/2 keyboard receiver: pop strobe, queue head and status.
// The slave modport is the receiver; the master modport is the bus decode that reads it.
interface ps2_kbd_rx_if;
    logic       rd;
    logic [7:0] ps2_key;
    logic       ps2_ready;
    logic       overflow;
    logic       frame_err;

    modport master (
        output rd,
        input  ps2_key,
        input  ps2_ready,
        input  overflow,
        input  frame_err
    );

    modport slave (
        input  rd,
        output ps2_key,
        output ps2_ready,
        output overflow,
        output frame_err
    );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the device clock, deframes 11-bit
// frames with odd parity, and queues accepted scan codes for the CPU to pop.
module ps2_kbd_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int FILT_LEN   = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    ps2_kbd_rx_if.slave  bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILT_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers (both idle high, so reset them high)
    // ------------------------------------------------------------------
    logic clk_meta, clk_sync;
    logic data_meta, data_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    // ------------------------------------------------------------------
    // Clock glitch filter: flip only after FILT_LEN consecutive differing samples
    // ------------------------------------------------------------------
    logic          filt_clk;
    logic          filt_prev;
    logic [FW-1:0] filt_cnt;
    logic          sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_sync == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
                filt_clk <= clk_sync;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign sample = filt_prev & ~filt_clk;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_bit;
    logic [TW-1:0] to_cnt;
    logic          frame_err_q;
    logic          frame_ok;
    logic          push;

    // Odd parity: the nine data+parity bits must XOR to 1, and stop must be high.
    assign frame_ok = data_sync & (^{shift, parity_bit});
    assign push     = sample && (state == STOP) && frame_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            parity_bit  <= 1'b0;
            to_cnt      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (sample) begin
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_sync) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_sync, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_bit <= data_sync;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!frame_ok) begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                // A stalled device must not leave a half frame pending forever.
                if (to_cnt == TW'(TIMEOUT - 1)) begin
                    state  <= IDLE;
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-code FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow_q;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign full = (count == CW'(FIFO_DEPTH));

    // NOTE: every signal driven here gets a default first, so no path can hold
    // a previous value and infer a latch.
    always_comb begin
        pop     = 1'b0;
        push_ok = 1'b0;
        drop    = 1'b0;
        if (bus.rd && (count != '0)) begin
            pop = 1'b1;
        end
        if (push) begin
            if (!full || pop) begin
                push_ok = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.rd) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // NOTE: storage has no reset; an entry is only visible once the count covers
    // it, and the head is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shift;
        end
    end

    assign bus.ps2_key   = (count == '0) ? 8'h00 : mem[rd_ptr];
    assign bus.ps2_ready = (count != '0);
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: bit-banged PS/2 frames with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_ps2_kbd_rx;

    localparam int TIMEOUT = 300;

    logic clk;
    logic rst;
    logic ps2_clk;
    logic ps2_data;

    ps2_kbd_rx_if bus ();

    ps2_kbd_rx #(
        .FIFO_DEPTH (8),
        .FILT_LEN   (8),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;
    int rdy_at;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) err_seen++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        idle_cycles(5);
        ps2_clk = 1'b0;
        idle_cycles(20);
        ps2_clk = 1'b1;
        idle_cycles(15);
    endtask

    // Data, parity and stop bits. The stop-bit low phase is watched cycle by cycle:
    // rdy_at records the first cycle after the fall with ps2_ready=1, and rd is
    // pulsed for one cycle at iteration rd_cycle (0 = never).
    task automatic send_tail(input logic [7:0] code, input logic bad_par, input int rd_cycle);
        logic par;
        par = ~(^code) ^ bad_par;
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(par);
        @(negedge clk);
        ps2_data = 1'b1;
        idle_cycles(5);
        ps2_clk = 1'b0;
        rdy_at  = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            bus.rd = (i == rd_cycle);
            if (rdy_at == 0 && bus.ps2_ready === 1'b1) rdy_at = i;
        end
        bus.rd  = 1'b0;
        ps2_clk = 1'b1;
        idle_cycles(15);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input int rd_cycle);
        send_bit(1'b0);
        send_tail(code, bad_par, rd_cycle);
    endtask

    task automatic pop();
        @(negedge clk);
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(2);
    endtask

    int e0;

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        bus.rd   = 1'b0;
        do_reset();

        check("rst_key", 32'(bus.ps2_key), 32'h00);
        check("rst_ready", 32'(bus.ps2_ready), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);

        // 0x1C, good parity: 2 sync + 8 filter + 1 edge detect cycles after the fall.
        e0 = err_seen;
        send_frame(8'h1C, 1'b0, 0);
        check("good_ready_latency", 32'(rdy_at), 32'd11);
        check("good_key", 32'(bus.ps2_key), 32'h1C);
        check("good_no_err", 32'(err_seen - e0), 32'd0);
        pop();
        check("good_pop_ready", 32'(bus.ps2_ready), 32'd0);
        check("good_pop_key", 32'(bus.ps2_key), 32'h00);

        // Same frame with flipped parity.
        e0 = err_seen;
        send_frame(8'h1C, 1'b1, 0);
        check("par_err_pulse_len", 32'(err_seen - e0), 32'd1);
        check("par_err_ready", 32'(bus.ps2_ready), 32'd0);

        // Nine codes into an eight-deep queue.
        for (int c = 1; c <= 9; c++) send_frame(8'(c), 1'b0, 0);
        check("ovf_set", 32'(bus.overflow), 32'd1);
        for (int c = 1; c <= 8; c++) begin
            check("ovf_pop_key", 32'(bus.ps2_key), 32'(c));
            pop();
            if (c == 1) check("ovf_clear_on_rd", 32'(bus.overflow), 32'd0);
        end
        check("ovf_drained", 32'(bus.ps2_ready), 32'd0);

        // Partial frame abandoned by timeout, then a clean 0xF0.
        e0 = err_seen;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        idle_cycles(TIMEOUT + 20);
        check("to_nothing_queued", 32'(bus.ps2_ready), 32'd0);
        send_frame(8'hF0, 1'b0, 0);
        check("to_key", 32'(bus.ps2_key), 32'hF0);
        check("to_no_err", 32'(err_seen - e0), 32'd0);
        pop();
        check("to_single_code", 32'(bus.ps2_ready), 32'd0);

        // Seven-cycle clock glitch in IDLE with data low must not start a frame.
        @(negedge clk);
        ps2_data = 1'b0;
        idle_cycles(3);
        ps2_clk = 1'b0;
        idle_cycles(7);
        ps2_clk = 1'b1;
        idle_cycles(20);
        send_frame(8'h5A, 1'b0, 0);
        check("glitch_ignored_key", 32'(bus.ps2_key), 32'h5A);
        pop();
        // An eight-cycle low is a real start bit.
        @(negedge clk);
        ps2_data = 1'b0;
        idle_cycles(3);
        ps2_clk = 1'b0;
        idle_cycles(8);
        ps2_clk = 1'b1;
        idle_cycles(20);
        send_tail(8'h33, 1'b0, 0);
        check("short_start_key", 32'(bus.ps2_key), 32'h33);
        pop();
        check("short_start_empty", 32'(bus.ps2_ready), 32'd0);

        // Full queue with rd landing on the push edge (the 11th edge after the fall).
        for (int c = 0; c < 8; c++) send_frame(8'h10 + 8'(c), 1'b0, 0);
        send_frame(8'h18, 1'b0, 10);
        check("full_rdwr_overflow", 32'(bus.overflow), 32'd0);
        for (int c = 1; c <= 8; c++) begin
            check("full_rdwr_key", 32'(bus.ps2_key), 32'h10 + 32'(c));
            pop();
        end
        check("full_rdwr_empty", 32'(bus.ps2_ready), 32'd0);

        // Reset in the middle of a frame.
        send_frame(8'h77, 1'b0, 0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        do_reset();
        check("midrst_ready", 32'(bus.ps2_ready), 32'd0);
        check("midrst_key", 32'(bus.ps2_key), 32'h00);
        send_frame(8'h2B, 1'b0, 0);
        check("midrst_fresh_key", 32'(bus.ps2_key), 32'h2B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, scan-code queue entries (power of two, 2..16).
REQ-002 Parameter FILT_LEN, default 8, consecutive equal samples needed to accept a PS/2 clock level.
REQ-003 Parameter TIMEOUT, default 50000, idle clk cycles that abort a partial frame.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  system clock; rst  input  1  synchronous active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock from the device, asynchronous.
REQ-006 ps2_data  input  1  raw PS/2 data from the device, asynchronous.
REQ-007 rd  input  1  one-cycle pop strobe, asserted by bus decode on a read of the PS/2 window.
REQ-008 ps2_key  output  8  scan code at the FIFO head.
REQ-009 ps2_ready  output  1  FIFO non-empty.
REQ-010 overflow  output  1  sticky flag: at least one code dropped.
REQ-011 frame_err  output  1  one-cycle pulse: frame discarded for parity or stop error.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 Filtered clock SHALL change level only after FILT_LEN consecutive equal synchronized samples; it resets to 1.
REQ-014 A sample event SHALL be a 1->0 transition of the filtered clock; ps2_data (synchronized) is sampled in that cycle.
REQ-015 FSM states: IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on a sample event with data=0, go to DATA with bit count 0; with data=1, stay in IDLE (bad start, no error pulse).
REQ-017 DATA: each sample event shifts data in LSB first; after the 8th bit go to PARITY.
REQ-018 PARITY: store the sampled bit, go to STOP.
REQ-019 STOP: on a sample event, accept the frame if stop=1 and the XOR of 8 data bits and parity is 1 (odd parity); otherwise discard and pulse frame_err for one cycle; return to IDLE in both cases.
REQ-020 An accepted code SHALL be written to the FIFO on the cycle after the stop-bit sample event.
REQ-021 In any state other than IDLE, TIMEOUT cycles without a sample event SHALL return to IDLE and discard the partial frame, with no frame_err; the counter clears on every sample event.
REQ-022 ps2_key SHALL present the FIFO head combinationally from FIFO storage; it SHALL read 8'h00 when empty.
REQ-023 ps2_ready SHALL equal not-empty.
REQ-024 rd with ps2_ready=1 SHALL pop one entry; the next head is visible the following cycle.
REQ-025 rd with ps2_ready=0 SHALL be ignored.
REQ-026 Push while full and no pop: drop the code and set overflow.
REQ-027 Push and pop in the same cycle while full: both SHALL take effect, count unchanged, no overflow.
REQ-028 Push and pop in the same cycle while empty: the push takes effect and the pop is ignored.
REQ-029 overflow SHALL clear on any rd strobe unless a drop occurs in the same cycle; a drop wins.
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the count range is 0..FIFO_DEPTH.

Reset
REQ-031 rst SHALL put the FSM in IDLE and clear the bit count, shift register, timeout counter and FIFO pointers/count.
REQ-032 Outputs after reset: ps2_key=0, ps2_ready=0, overflow=0, frame_err=0; the filter state is 1.
REQ-033 rst asserted mid-frame SHALL discard the frame; the next valid start bit begins a fresh frame.

Verification
REQ-034 Frame 0,0x1C LSB-first, parity 0, stop 1 -> ps2_ready=1 and ps2_key=8'h1C one cycle after the stop sample; rd -> ps2_ready=0 next cycle.
REQ-035 Same frame with parity 1 -> frame_err high exactly 1 cycle; ps2_ready stays 0.
REQ-036 9 valid codes 0x01..0x09 without rd (DEPTH=8) -> overflow=1; eight rd pops return 0x01..0x08 in order; overflow clears on the first rd.
REQ-037 Start bit plus 3 data bits, then silence for TIMEOUT+1 cycles, then a valid 0xF0 frame -> only 0xF0 is queued, with no frame_err.
REQ-038 ps2_clk glitch low for FILT_LEN-1 cycles during IDLE with data=0 -> no state change; a full-length low is accepted as a sample.
REQ-039 FIFO full, with rd coinciding with a push cycle -> count stays 8, overflow stays 0, and the new code is last in order.
